// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants and types for the ID/EX issue path into the EX-stage ALU.
//   - ALU operation codes produced by the decoder (AND..XOR)
//   - MIPS opcode / funct field encodings that the decoder recognises
//   - operand-2 select enum (register rt, sign-extended imm, zero-extended imm)
//   - control-field struct of the ID/EX register and its bubble value
// No ports: this is a package.
// ---------------------------------------------------------------------------
package alu_pkg;

    // ALU operation codes; no other code is ever produced.
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SLL = 4'd3;
    localparam logic [3:0] ALU_SRL = 4'd4;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;
    localparam logic [3:0] ALU_XOR = 4'd13;

    // Opcodes (instruction [31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (instruction [5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // Where ALU operand 2 comes from.
    typedef enum logic [1:0] {
        SRC2_RT   = 2'd0,
        SRC2_SEXT = 2'd1,
        SRC2_ZEXT = 2'd2
    } src2_sel_e;

    // Width-independent control fields of the ID/EX register.
    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic [3:0] alu_ctrl;
        logic [4:0] shamt;
    } idex_ctrl_t;

    // Bubble: no instruction, AND opcode, zero shift. Operands are zeroed
    // separately because their width depends on the datapath parameter.
    localparam idex_ctrl_t IDEX_CTRL_BUBBLE = '{
        valid:    1'b0,
        illegal:  1'b0,
        alu_ctrl: ALU_AND,
        shamt:    5'd0
    };

endpackage

// File: rtl/alu_op_decode.sv
// ---------------------------------------------------------------------------
// alu_op_decode
// Purely combinational decode of the opcode/funct fields into the ALU code,
// the operand-2 source and whether the shamt field is meaningful.
// Ports:
//   opcode    in  [5:0]  instruction [31:26]
//   funct     in  [5:0]  instruction [5:0]
//   alu_ctrl  out [3:0]  ALU operation code (ADD for unsupported encodings)
//   src2_sel  out        operand-2 select (rt / sext imm / zext imm)
//   shamt_use out        instruction is SLL or SRL
//   illegal   out        opcode/funct combination not supported
// ---------------------------------------------------------------------------
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output src2_sel_e  src2_sel,
    output logic       shamt_use,
    output logic       illegal
);

    always_comb begin
        alu_ctrl  = ALU_ADD;
        src2_sel  = SRC2_RT;
        shamt_use = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: alu_ctrl = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_ctrl = ALU_SUB;
                    FN_AND:          alu_ctrl = ALU_AND;
                    FN_OR:           alu_ctrl = ALU_OR;
                    FN_XOR:          alu_ctrl = ALU_XOR;
                    FN_NOR:          alu_ctrl = ALU_NOR;
                    FN_SLT:          alu_ctrl = ALU_SLT;
                    FN_JR:           alu_ctrl = ALU_ADD;
                    FN_SLL: begin
                        alu_ctrl  = ALU_SLL;
                        shamt_use = 1'b1;
                    end
                    FN_SRL: begin
                        alu_ctrl  = ALU_SRL;
                        shamt_use = 1'b1;
                    end
                    default:         illegal  = 1'b1;
                endcase
            end
            OP_ADDI: begin
                alu_ctrl = ALU_ADD;
                src2_sel = SRC2_SEXT;
            end
            OP_SLTI: begin
                alu_ctrl = ALU_SLT;
                src2_sel = SRC2_SEXT;
            end
            OP_ANDI: begin
                alu_ctrl = ALU_AND;
                src2_sel = SRC2_ZEXT;
            end
            OP_ORI: begin
                alu_ctrl = ALU_OR;
                src2_sel = SRC2_ZEXT;
            end
            OP_XORI: begin
                alu_ctrl = ALU_XOR;
                src2_sel = SRC2_ZEXT;
            end
            OP_LW, OP_SW: begin
                alu_ctrl = ALU_ADD;
                src2_sel = SRC2_SEXT;
            end
            // Branches compare rs against rt; the ALU Zero flag resolves them.
            OP_BEQ, OP_BNE: alu_ctrl = ALU_SUB;
            default:        illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_idex_issue.sv
// ---------------------------------------------------------------------------
// alu_idex_issue
// Decodes the ID-stage instruction, selects/extends the ALU operands and
// registers them into the ID/EX pipeline register (one cycle latency).
// Update priority each clock: flush (bubble) > stall (hold) > load.
// Optional macro ALU_FWD_EN adds EX/MEM and MEM/WB operand forwarding.
// Ports:
//   clk, rst                     clock (rising), async active-low reset
//   id_valid/opcode/funct/shamt/imm, id_rs_data, id_rt_data   ID inputs
//   stall, flush                 pipeline control
//   ex_valid, ex_ALUControl, ex_src1, ex_src2, ex_shamt, ex_illegal
//                                registered EX-stage outputs
//   ALU_FWD_EN only: id_rs, id_rt, mem_wr_en/addr/data, wb_wr_en/addr/data
// ---------------------------------------------------------------------------
module alu_idex_issue
    import alu_pkg::*;
#(
    parameter int bit_size = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [5:0]          id_opcode,
    input  logic [5:0]          id_funct,
    input  logic [4:0]          id_shamt,
    input  logic [15:0]         id_imm,
    input  logic [bit_size-1:0] id_rs_data,
    input  logic [bit_size-1:0] id_rt_data,
`ifdef ALU_FWD_EN
    input  logic [4:0]          id_rs,
    input  logic [4:0]          id_rt,
    input  logic                mem_wr_en,
    input  logic [4:0]          mem_wr_addr,
    input  logic [bit_size-1:0] mem_wr_data,
    input  logic                wb_wr_en,
    input  logic [4:0]          wb_wr_addr,
    input  logic [bit_size-1:0] wb_wr_data,
`endif
    input  logic                stall,
    input  logic                flush,
    output logic                ex_valid,
    output logic [3:0]          ex_ALUControl,
    output logic [bit_size-1:0] ex_src1,
    output logic [bit_size-1:0] ex_src2,
    output logic [4:0]          ex_shamt,
    output logic                ex_illegal
);

    logic [3:0]          dec_alu_ctrl;
    src2_sel_e           dec_src2_sel;
    logic                dec_shamt_use;
    logic                dec_illegal;

    logic [bit_size-1:0] rs_val;
    logic [bit_size-1:0] rt_val;
    logic [bit_size-1:0] src1_dec;
    logic [bit_size-1:0] src2_dec;
    idex_ctrl_t          ctrl_dec;

    idex_ctrl_t          ctrl_d, ctrl_q;
    logic [bit_size-1:0] src1_d, src1_q;
    logic [bit_size-1:0] src2_d, src2_q;

    alu_op_decode u_decode (
        .opcode    (id_opcode),
        .funct     (id_funct),
        .alu_ctrl  (dec_alu_ctrl),
        .src2_sel  (dec_src2_sel),
        .shamt_use (dec_shamt_use),
        .illegal   (dec_illegal)
    );

`ifdef ALU_FWD_EN
    // MEM result is younger than WB, so it wins; $zero is never forwarded.
    always_comb begin
        rs_val = id_rs_data;
        rt_val = id_rt_data;
        if (mem_wr_en && mem_wr_addr != 5'd0 && mem_wr_addr == id_rs)
            rs_val = mem_wr_data;
        else if (wb_wr_en && wb_wr_addr != 5'd0 && wb_wr_addr == id_rs)
            rs_val = wb_wr_data;
        if (mem_wr_en && mem_wr_addr != 5'd0 && mem_wr_addr == id_rt)
            rt_val = mem_wr_data;
        else if (wb_wr_en && wb_wr_addr != 5'd0 && wb_wr_addr == id_rt)
            rt_val = wb_wr_data;
    end
`else
    assign rs_val = id_rs_data;
    assign rt_val = id_rt_data;
`endif

    // Operand selection; an unsupported instruction issues ADD 0+0 with the
    // illegal flag so EX produces a harmless result while the trap is raised.
    always_comb begin
        src1_dec = rs_val;
        case (dec_src2_sel)
            SRC2_SEXT: src2_dec = {{(bit_size-16){id_imm[15]}}, id_imm};
            SRC2_ZEXT: src2_dec = {{(bit_size-16){1'b0}}, id_imm};
            default:   src2_dec = rt_val;
        endcase
        ctrl_dec.valid    = 1'b1;
        ctrl_dec.illegal  = dec_illegal;
        ctrl_dec.alu_ctrl = dec_alu_ctrl;
        ctrl_dec.shamt    = dec_shamt_use ? id_shamt : 5'd0;
        if (dec_illegal) begin
            src1_dec = '0;
            src2_dec = '0;
        end
    end

    // ID/EX next state: flush > stall > load; an invalid ID slot loads a bubble.
    always_comb begin
        ctrl_d = ctrl_q;
        src1_d = src1_q;
        src2_d = src2_q;
        if (flush || (!stall && !id_valid)) begin
            ctrl_d = IDEX_CTRL_BUBBLE;
            src1_d = '0;
            src2_d = '0;
        end else if (!stall) begin
            ctrl_d = ctrl_dec;
            src1_d = src1_dec;
            src2_d = src2_dec;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q <= '0;
            src1_q <= '0;
            src2_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            src1_q <= src1_d;
            src2_q <= src2_d;
        end
    end

    assign ex_valid      = ctrl_q.valid;
    assign ex_illegal    = ctrl_q.illegal;
    assign ex_ALUControl = ctrl_q.alu_ctrl;
    assign ex_shamt      = ctrl_q.shamt;
    assign ex_src1       = src1_q;
    assign ex_src2       = src2_q;

endmodule

// File: tb/tb_alu_idex_issue.sv
// ---------------------------------------------------------------------------
// tb_alu_idex_issue
// Directed stimulus for alu_idex_issue. Each step drives the ID inputs on the
// falling edge and queues the expected EX outputs; after the next rising edge
// the entry is popped and compared field by field.
// Define ALU_FWD_EN to include the forwarding steps.
// ---------------------------------------------------------------------------
module tb_alu_idex_issue;

    typedef struct {
        logic        valid;
        logic        illegal;
        logic [3:0]  ctl;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [4:0]  shamt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [5:0]  id_opcode;
    logic [5:0]  id_funct;
    logic [4:0]  id_shamt;
    logic [15:0] id_imm;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [3:0]  ex_ALUControl;
    logic [31:0] ex_src1;
    logic [31:0] ex_src2;
    logic [4:0]  ex_shamt;
    logic        ex_illegal;
`ifdef ALU_FWD_EN
    logic [4:0]  id_rs = 5'd0;
    logic [4:0]  id_rt = 5'd0;
    logic        mem_wr_en = 1'b0;
    logic [4:0]  mem_wr_addr = 5'd0;
    logic [31:0] mem_wr_data = '0;
    logic        wb_wr_en = 1'b0;
    logic [4:0]  wb_wr_addr = 5'd0;
    logic [31:0] wb_wr_data = '0;
`endif

    int   checks = 0;
    int   passed = 0;
    int   fails  = 0;
    exp_t sb_q[$];
    exp_t last;

    always #5 clk = ~clk;

    alu_idex_issue #(.bit_size(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_opcode     (id_opcode),
        .id_funct      (id_funct),
        .id_shamt      (id_shamt),
        .id_imm        (id_imm),
        .id_rs_data    (id_rs_data),
        .id_rt_data    (id_rt_data),
`ifdef ALU_FWD_EN
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .mem_wr_en     (mem_wr_en),
        .mem_wr_addr   (mem_wr_addr),
        .mem_wr_data   (mem_wr_data),
        .wb_wr_en      (wb_wr_en),
        .wb_wr_addr    (wb_wr_addr),
        .wb_wr_data    (wb_wr_data),
`endif
        .stall         (stall),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_ALUControl (ex_ALUControl),
        .ex_src1       (ex_src1),
        .ex_src2       (ex_src2),
        .ex_shamt      (ex_shamt),
        .ex_illegal    (ex_illegal)
    );

    function automatic exp_t mk(input logic v, input logic ill, input logic [3:0] c,
                                input logic [31:0] s1, input logic [31:0] s2,
                                input logic [4:0] sh);
        exp_t e;
        e.valid = v; e.illegal = ill; e.ctl = c;
        e.src1 = s1; e.src2 = s2; e.shamt = sh;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic checkOutput(input string tag, input exp_t e);
        check({tag, ".valid"},   {31'd0, ex_valid},      {31'd0, e.valid});
        check({tag, ".illegal"}, {31'd0, ex_illegal},    {31'd0, e.illegal});
        check({tag, ".ctl"},     {28'd0, ex_ALUControl}, {28'd0, e.ctl});
        check({tag, ".src1"},    ex_src1,                e.src1);
        check({tag, ".src2"},    ex_src2,                e.src2);
        check({tag, ".shamt"},   {27'd0, ex_shamt},      {27'd0, e.shamt});
    endtask

    // Drive one ID instruction plus stall/flush, queue the expected EX result.
    task automatic applyStimulus(input string tag, input logic v, input logic [5:0] op,
                                 input logic [5:0] fn, input logic [4:0] sh,
                                 input logic [15:0] imm, input logic [31:0] rs,
                                 input logic [31:0] rt, input logic st, input logic fl,
                                 input exp_t e);
        exp_t got;
        @(negedge clk);
        id_valid = v; id_opcode = op; id_funct = fn; id_shamt = sh;
        id_imm = imm; id_rs_data = rs; id_rt_data = rt; stall = st; flush = fl;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        checkOutput(tag, got);
        last = got;
    endtask

    exp_t zero;

    initial begin
        zero = mk(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        rst = 1'b0; id_valid = 1'b0; id_opcode = '0; id_funct = '0; id_shamt = '0;
        id_imm = '0; id_rs_data = '0; id_rt_data = '0; stall = 1'b0; flush = 1'b0;
        #1;
        checkOutput("reset_init", zero);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        applyStimulus("add", 1, 6'h00, 6'h20, 5'd0, 16'h0, 32'd5, 32'd7, 0, 0, mk(1, 0, 4'd2, 32'd5, 32'd7, 5'd0));
        applyStimulus("addi", 1, 6'h08, 6'h00, 5'd0, 16'hFFFF, 32'd1, 32'd9, 0, 0, mk(1, 0, 4'd2, 32'd1, 32'hFFFF_FFFF, 5'd0));
        applyStimulus("ori", 1, 6'h0D, 6'h00, 5'd0, 16'hFFFF, 32'd1, 32'd9, 0, 0, mk(1, 0, 4'd1, 32'd1, 32'h0000_FFFF, 5'd0));
        applyStimulus("sll", 1, 6'h00, 6'h00, 5'd4, 16'h0, 32'd9, 32'd3, 0, 0, mk(1, 0, 4'd3, 32'd9, 32'd3, 5'd4));
        applyStimulus("beq", 1, 6'h04, 6'h00, 5'd7, 16'h0010, 32'h21, 32'h22, 0, 0, mk(1, 0, 4'd6, 32'h21, 32'h22, 5'd0));

        // Hold for three cycles while the ID inputs keep changing.
        applyStimulus("stall1", 1, 6'h00, 6'h25, 5'd1, 16'h1, 32'h31, 32'h32, 1, 0, last);
        applyStimulus("stall2", 1, 6'h08, 6'h00, 5'd2, 16'h2, 32'h41, 32'h42, 1, 0, last);
        applyStimulus("stall3", 0, 6'h3F, 6'h3F, 5'd3, 16'h3, 32'h51, 32'h52, 1, 0, last);
        applyStimulus("stall_flush", 1, 6'h00, 6'h20, 5'd0, 16'h0, 32'd5, 32'd7, 1, 1, zero);

        applyStimulus("illegal_op", 1, 6'h3F, 6'h20, 5'd5, 16'h1234, 32'hDEAD, 32'hBEEF, 0, 0, mk(1, 1, 4'd2, 32'd0, 32'd0, 5'd0));
        applyStimulus("slt", 1, 6'h00, 6'h2A, 5'd0, 16'h0, 32'd3, 32'd4, 0, 0, mk(1, 0, 4'd7, 32'd3, 32'd4, 5'd0));
        applyStimulus("illegal_fn", 1, 6'h00, 6'h3F, 5'd0, 16'h0, 32'd3, 32'd4, 0, 0, mk(1, 1, 4'd2, 32'd0, 32'd0, 5'd0));
        applyStimulus("id_invalid", 0, 6'h00, 6'h20, 5'd0, 16'h0, 32'd5, 32'd7, 0, 0, zero);
        applyStimulus("flush_only", 1, 6'h00, 6'h21, 5'd0, 16'h0, 32'd5, 32'd7, 0, 1, zero);

        applyStimulus("addu", 1, 6'h00, 6'h21, 5'd0, 16'h0, 32'h100, 32'h200, 0, 0, mk(1, 0, 4'd2, 32'h100, 32'h200, 5'd0));
        applyStimulus("sub", 1, 6'h00, 6'h22, 5'd0, 16'h0, 32'h10, 32'h20, 0, 0, mk(1, 0, 4'd6, 32'h10, 32'h20, 5'd0));
        applyStimulus("subu", 1, 6'h00, 6'h23, 5'd0, 16'h0, 32'h11, 32'h21, 0, 0, mk(1, 0, 4'd6, 32'h11, 32'h21, 5'd0));
        applyStimulus("and", 1, 6'h00, 6'h24, 5'd0, 16'h0, 32'hF0, 32'h0F, 0, 0, mk(1, 0, 4'd0, 32'hF0, 32'h0F, 5'd0));
        applyStimulus("or", 1, 6'h00, 6'h25, 5'd0, 16'h0, 32'hA0, 32'h0A, 0, 0, mk(1, 0, 4'd1, 32'hA0, 32'h0A, 5'd0));
        applyStimulus("xor", 1, 6'h00, 6'h26, 5'd0, 16'h0, 32'hAA, 32'h55, 0, 0, mk(1, 0, 4'd13, 32'hAA, 32'h55, 5'd0));
        applyStimulus("nor", 1, 6'h00, 6'h27, 5'd0, 16'h0, 32'h1, 32'h2, 0, 0, mk(1, 0, 4'd12, 32'h1, 32'h2, 5'd0));
        applyStimulus("srl", 1, 6'h00, 6'h02, 5'd31, 16'h0, 32'h8, 32'h8000_0000, 0, 0, mk(1, 0, 4'd4, 32'h8, 32'h8000_0000, 5'd31));
        applyStimulus("jr", 1, 6'h00, 6'h08, 5'd9, 16'h0, 32'h400, 32'h0, 0, 0, mk(1, 0, 4'd2, 32'h400, 32'h0, 5'd0));
        applyStimulus("slti", 1, 6'h0A, 6'h00, 5'd0, 16'h8000, 32'h7, 32'h9, 0, 0, mk(1, 0, 4'd7, 32'h7, 32'hFFFF_8000, 5'd0));
        applyStimulus("andi", 1, 6'h0C, 6'h00, 5'd0, 16'h8001, 32'h7, 32'h9, 0, 0, mk(1, 0, 4'd0, 32'h7, 32'h0000_8001, 5'd0));
        applyStimulus("xori", 1, 6'h0E, 6'h00, 5'd0, 16'hF0F0, 32'h7, 32'h9, 0, 0, mk(1, 0, 4'd13, 32'h7, 32'h0000_F0F0, 5'd0));
        applyStimulus("lw", 1, 6'h23, 6'h00, 5'd0, 16'hFFFC, 32'h1000, 32'h9, 0, 0, mk(1, 0, 4'd2, 32'h1000, 32'hFFFF_FFFC, 5'd0));
        applyStimulus("sw", 1, 6'h2B, 6'h00, 5'd0, 16'h7FFF, 32'h2000, 32'h9, 0, 0, mk(1, 0, 4'd2, 32'h2000, 32'h0000_7FFF, 5'd0));
        applyStimulus("bne", 1, 6'h05, 6'h00, 5'd3, 16'h1234, 32'h66, 32'h55, 0, 0, mk(1, 0, 4'd6, 32'h66, 32'h55, 5'd0));

        // Asynchronous reset mid-cycle: outputs clear without a clock edge.
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_async", zero);
        @(posedge clk);
        #1;
        checkOutput("reset_held", zero);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus("add_after_rst", 1, 6'h00, 6'h20, 5'd0, 16'h0, 32'd5, 32'd7, 0, 0, mk(1, 0, 4'd2, 32'd5, 32'd7, 5'd0));

        // Reset while stalled drops the held instruction.
        applyStimulus("stall_pre_rst", 1, 6'h00, 6'h22, 5'd0, 16'h0, 32'd1, 32'd2, 1, 0, last);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_in_stall", zero);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus("stall_post_rst", 1, 6'h00, 6'h22, 5'd0, 16'h0, 32'd1, 32'd2, 1, 0, zero);

`ifdef ALU_FWD_EN
        id_rs = 5'd8; id_rt = 5'd9;
        mem_wr_en = 1'b1; mem_wr_addr = 5'd8; mem_wr_data = 32'hAA;
        wb_wr_en  = 1'b1; wb_wr_addr  = 5'd8; wb_wr_data  = 32'hBB;
        applyStimulus("fwd_mem_prio", 1, 6'h00, 6'h20, 5'd0, 16'h0, 32'h11, 32'h22, 0, 0, mk(1, 0, 4'd2, 32'hAA, 32'h22, 5'd0));
        wb_wr_addr = 5'd9;
        applyStimulus("fwd_wb_rt", 1, 6'h00, 6'h20, 5'd0, 16'h0, 32'h11, 32'h22, 0, 0, mk(1, 0, 4'd2, 32'hAA, 32'hBB, 5'd0));
        id_rs = 5'd0; id_rt = 5'd0; mem_wr_addr = 5'd0; wb_wr_addr = 5'd0;
        applyStimulus("fwd_reg0", 1, 6'h00, 6'h20, 5'd0, 16'h0, 32'h11, 32'h22, 0, 0, mk(1, 0, 4'd2, 32'h11, 32'h22, 5'd0));
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Guard against a stuck simulation.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
